// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        FULL = 3'd3,
        ERR  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_TIMEOUT  = 2'b10
    } fault_t;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    function automatic logic is_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_timeout_cnt.sv
// 8-bit clear/enable counter; tc flags the last permitted WAIT cycle.
module ifetch_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic areset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] TC_VAL = 8'(LIMIT - 1);

    logic [7:0] count_q;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset)
            count_q <= '0;
        else if (clr)
            count_q <= '0;
        else if (en)
            count_q <= count_q + 8'd1;
    end

    assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: one imem read per instruction, held for
// decode, with a pc_load strobe on consumption plus misalign/timeout faults.
module ifetch_ctrl #(
    parameter int              XLEN           = 32,
    parameter int              TIMEOUT_CYCLES = 255,
    parameter logic [XLEN-1:0] NOP_INSTR      = ifetch_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            areset,
    input  logic [XLEN-1:0] pc,
    output logic            pc_load,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [1:0]      instr_fault,
    output logic [31:0]     fetch_count
);

    import ifetch_pkg::*;

    state_t          state_q, state_d;
    fault_t          fault_q;
    logic [XLEN-1:0] instr_q, instr_pc_q;
    logic [31:0]     fetch_cnt_q;
    logic            misaligned;
    logic            cnt_clr, cnt_en, cnt_tc;

    assign misaligned = is_misaligned(pc[1:0]);

    // Counter is held clear for the whole of REQ, so it starts at 0 on WAIT entry.
    assign cnt_clr = (state_q == REQ);
    assign cnt_en  = (state_q == WAIT) && !imem_rsp_valid && !cnt_tc;

    ifetch_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .areset (areset),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .tc     (cnt_tc)
    );

    always_ff @(posedge clk or negedge areset) begin
        if (!areset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (misaligned)
                    state_d = FULL;
                else if (imem_req_ready)
                    state_d = WAIT;
            end
            // A response on the terminal count beats the timeout.
            WAIT: begin
                if (imem_rsp_valid)
                    state_d = FULL;
                else if (cnt_tc)
                    state_d = ERR;
            end
            FULL: begin
                if (instr_ready)
                    state_d = REQ;
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        imem_addr      = '0;
        instr_valid    = 1'b0;
        pc_load        = 1'b0;
        case (state_q)
            REQ: begin
                if (!misaligned) begin
                    imem_req_valid = 1'b1;
                    imem_addr      = pc;
                end
            end
            FULL: begin
                instr_valid = 1'b1;
                pc_load     = instr_ready && (fault_q != FAULT_TIMEOUT);
            end
            ERR:     instr_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            instr_q     <= '0;
            instr_pc_q  <= '0;
            fault_q     <= FAULT_NONE;
            fetch_cnt_q <= '0;
        end else begin
            case (state_q)
                REQ: begin
                    if (misaligned) begin
                        instr_q    <= NOP_INSTR;
                        instr_pc_q <= pc;
                        fault_q    <= FAULT_MISALIGN;
                    end else if (imem_req_ready) begin
                        instr_pc_q <= pc;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        instr_q <= imem_rsp_data;
                        fault_q <= FAULT_NONE;
                    end else if (cnt_tc) begin
                        instr_q <= NOP_INSTR;
                        fault_q <= FAULT_TIMEOUT;
                    end
                end
                FULL: begin
                    if (instr_ready)
                        fetch_cnt_q <= fetch_cnt_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_fault = fault_q;
    assign fetch_count = fetch_cnt_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed vector bench for ifetch_ctrl with hand-written multi-cycle sequences.
module tb_ifetch_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            areset = 1'b0;
    logic [XLEN-1:0] pc = '0;
    logic            pc_load;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [XLEN-1:0] imem_rsp_data = '0;
    logic            instr_valid;
    logic            instr_ready = 1'b0;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic [1:0]      instr_fault;
    logic [31:0]     fetch_count;

    always #5 clk = ~clk;

    ifetch_ctrl #(
        .XLEN           (XLEN),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .areset         (areset),
        .pc             (pc),
        .pc_load        (pc_load),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_fault    (instr_fault),
        .fetch_count    (fetch_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic        rrdy;
        logic        rvld;
        logic [31:0] rdata;
        logic        irdy;
        logic        erv;
        logic [31:0] eaddr;
        logic        epcl;
        logic        eiv;
        logic [31:0] einstr;
        logic [31:0] eipc;
        logic [1:0]  ef;
        logic [31:0] efc;
    } vec_t;

    vec_t vecs[$];
    int   nvec = 0;
    int   nmis = 0;

    function automatic logic [132:0] pk(logic rv, logic [31:0] addr, logic pcl, logic iv,
                                        logic [31:0] ins, logic [31:0] ipc, logic [1:0] f,
                                        logic [31:0] fc);
        return {rv, addr, pcl, iv, ins, ipc, f, fc};
    endfunction

    function automatic logic [132:0] act();
        return pk(imem_req_valid, imem_addr, pc_load, instr_valid, instr, instr_pc,
                  instr_fault, fetch_count);
    endfunction

    task automatic check(input string name, input logic [132:0] a, input logic [132:0] e);
        nvec++;
        if (a !== e) begin
            nmis++;
            $display("FAIL %s got %h want %h", name, a, e);
        end
    endtask

    task automatic drive(input logic [31:0] p, input logic rr, input logic rv,
                         input logic [31:0] rd, input logic ir);
        pc = p; imem_req_ready = rr; imem_rsp_valid = rv; imem_rsp_data = rd; instr_ready = ir;
    endtask

    task automatic add(input logic [31:0] p, input logic rr, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic erv, input logic [31:0] ea, input logic epcl,
                       input logic eiv, input logic [31:0] ei, input logic [31:0] eipc,
                       input logic [1:0] ef, input logic [31:0] efc);
        vec_t v;
        v.pc = p; v.rrdy = rr; v.rvld = rv; v.rdata = rd; v.irdy = ir;
        v.erv = erv; v.eaddr = ea; v.epcl = epcl; v.eiv = eiv;
        v.einstr = ei; v.eipc = eipc; v.ef = ef; v.efc = efc;
        vecs.push_back(v);
    endtask

    initial begin
        // pc   rrdy rvld rdata        irdy | rv addr       pcl iv instr        ipc        f  fc
        add(32'h0,   0, 0, 32'h0,        0,   0, 32'h0,   0, 0, 32'h0,        32'h0,   0, 0); // IDLE
        add(32'h0,   1, 1, 32'hdeadbeef, 0,   1, 32'h0,   0, 0, 32'h0,        32'h0,   0, 0); // REQ accept, rsp ignored
        add(32'h0,   0, 1, 32'h00500093, 0,   0, 32'h0,   0, 0, 32'h0,        32'h0,   0, 0); // WAIT rsp
        add(32'h0,   0, 0, 32'h0,        1,   0, 32'h0,   1, 1, 32'h00500093, 32'h0,   0, 0); // FULL consume
        add(32'h4,   1, 0, 32'h0,        0,   1, 32'h4,   0, 0, 32'h00500093, 32'h0,   0, 1); // REQ pc=4
        add(32'h4,   0, 1, 32'haaaa0001, 0,   0, 32'h0,   0, 0, 32'h00500093, 32'h4,   0, 1);
        for (int i = 0; i < 5; i++)
            add(32'h4, 0, 0, 32'h0,      0,   0, 32'h0,   0, 1, 32'haaaa0001, 32'h4,   0, 1); // decode stall
        add(32'h4,   0, 0, 32'h0,        1,   0, 32'h0,   1, 1, 32'haaaa0001, 32'h4,   0, 1);
        for (int i = 0; i < 4; i++)
            add(32'h100, 0, 0, 32'h0,    0,   1, 32'h100, 0, 0, 32'haaaa0001, 32'h4,   0, 2); // req stall
        add(32'h100, 1, 0, 32'h0,        0,   1, 32'h100, 0, 0, 32'haaaa0001, 32'h4,   0, 2);
        add(32'h100, 0, 0, 32'h0,        0,   0, 32'h0,   0, 0, 32'haaaa0001, 32'h100, 0, 2); // in WAIT
        add(32'h100, 0, 1, 32'h12345678, 0,   0, 32'h0,   0, 0, 32'haaaa0001, 32'h100, 0, 2);
        add(32'h100, 0, 0, 32'h0,        1,   0, 32'h0,   1, 1, 32'h12345678, 32'h100, 0, 2);
        add(32'h102, 1, 0, 32'h0,        0,   0, 32'h0,   0, 0, 32'h12345678, 32'h100, 0, 3); // misaligned REQ
        add(32'h102, 0, 1, 32'hdead0000, 0,   0, 32'h0,   0, 1, 32'h00000013, 32'h102, 1, 3);
        add(32'h102, 0, 0, 32'h0,        1,   0, 32'h0,   1, 1, 32'h00000013, 32'h102, 1, 3);

        // Reset state with busy-looking inputs
        drive(32'h44, 1, 1, 32'hffffffff, 1);
        @(negedge clk); @(negedge clk);
        #1 check("reset_state", act(), pk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        areset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].pc, vecs[i].rrdy, vecs[i].rvld, vecs[i].rdata, vecs[i].irdy);
            #1 check($sformatf("vec%0d", i), act(),
                     pk(vecs[i].erv, vecs[i].eaddr, vecs[i].epcl, vecs[i].eiv, vecs[i].einstr,
                        vecs[i].eipc, vecs[i].ef, vecs[i].efc));
            @(negedge clk);
        end

        // Response arriving on the final WAIT count still completes the fetch
        drive(32'h200, 1, 0, 0, 0);
        @(negedge clk);
        drive(32'h200, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("late_wait%0d", i), {132'd0, instr_valid}, 133'd0);
            @(negedge clk);
        end
        drive(32'h200, 0, 1, 32'h0badf00d, 0);
        @(negedge clk);
        #1 check("late_rsp_full", act(), pk(0, 0, 0, 1, 32'h0badf00d, 32'h200, 0, 4));
        drive(32'h200, 0, 0, 0, 1);
        #1 check("late_rsp_load", {132'd0, pc_load}, 133'd1);
        @(negedge clk);

        // Timeout: four silent WAIT cycles then terminal ERR
        drive(32'h300, 1, 0, 0, 0);
        @(negedge clk);
        drive(32'h300, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("to_wait%0d", i), {132'd0, instr_valid}, 133'd0);
            @(negedge clk);
        end
        drive(32'h300, 0, 0, 0, 1);
        #1 check("to_err", act(), pk(0, 0, 0, 1, 32'h13, 32'h300, 2, 5));
        @(negedge clk);
        drive(32'h300, 0, 1, 32'h1234, 1);
        #1 check("to_err_rsp", act(), pk(0, 0, 0, 1, 32'h13, 32'h300, 2, 5));
        @(negedge clk);
        #1 check("to_err_hold", act(), pk(0, 0, 0, 1, 32'h13, 32'h300, 2, 5));
        areset = 1'b0;
        #1 check("to_reset", act(), pk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        areset = 1'b1;

        // Asynchronous reset mid-WAIT clears without a clock edge
        drive(32'h40, 1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        drive(32'h40, 0, 0, 0, 0);
        #1 check("midwait_pc", {101'd0, instr_pc}, {101'd0, 32'h40});
        #1 areset = 1'b0;
        #1 check("midwait_reset", {101'd0, instr_pc}, 133'd0);
        check("midwait_state", {130'd0, dut.state_q}, {130'd0, ifetch_pkg::IDLE});
        @(negedge clk);
        areset = 1'b1;

        // fetch_count wraps from all-ones to zero
        drive(32'h80, 1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        drive(32'h80, 0, 1, 32'h00000073, 0);
        @(negedge clk);
        drive(32'h80, 0, 0, 0, 0);
        force dut.fetch_cnt_q = 32'hffffffff;
        #1 release dut.fetch_cnt_q;
        #1 check("wrap_preload", {101'd0, fetch_count}, {101'd0, 32'hffffffff});
        drive(32'h80, 0, 0, 0, 1);
        #1 check("wrap_load", {132'd0, pc_load}, 133'd1);
        @(negedge clk);
        #1 check("wrap_count", {100'd0, pc_load, fetch_count}, 133'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch controller immediately downstream of the PC calculation stage.
- Takes the current program counter and issues one read per instruction to instruction memory over a valid/ready request channel.
- Captures the returned word and presents it to decode with a valid/ready handshake.
- Generates the single-cycle `pc_load` strobe that advances the PC register once decode has consumed the instruction. It also detects misaligned PCs and memory timeouts.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before a bus-timeout fault; range 1..255.
- NOP_INSTR, 32'h00000013, instruction word presented on any fault (addi x0,x0,0).

Ports:
- clk  in  1  clock
- areset  in  1  asynchronous active-low reset
- pc  in  XLEN  current program counter from the PC stage
- pc_load  out  1  one-cycle strobe to the PC stage load input
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  XLEN  read address
- imem_rsp_valid  in  1  read data valid
- imem_rsp_data  in  XLEN  read data
- instr_valid  out  1  instruction held for decode
- instr_ready  in  1  decode consumes instruction
- instr  out  XLEN  fetched instruction
- instr_pc  out  XLEN  PC of the held instruction
- instr_fault  out  2  00 none, 01 misaligned, 10 bus timeout
- fetch_count  out  32  retired-fetch counter

Behaviour:
- Reset uses areset, asynchronous and active-low, on clock clk. On reset: state=IDLE, instr=0, instr_pc=0, instr_fault=00, fetch_count=0, timeout counter=0. All strobes/valids are 0.
- State encodings come from the package. Outputs are decoded from state, so none toggle during reset.
- IDLE: goes to REQ unconditionally on the next edge.
- REQ:
  - If pc[1:0]!=00: no request is issued. Latch instr=NOP_INSTR, instr_pc=pc, instr_fault=01, then go to FULL.
  - Otherwise: imem_req_valid=1 and imem_addr=pc (combinational from pc). When imem_req_ready=1, latch instr_pc=pc, clear the timeout counter, and go to WAIT. imem_req_valid stays high until accepted.
- WAIT:
  - On imem_rsp_valid=1: latch instr=imem_rsp_data, instr_fault=00, then go to FULL.
  - Otherwise the timeout counter increments. When the counter equals TIMEOUT_CYCLES-1 with no response: latch instr=NOP_INSTR, instr_fault=10, then go to ERR.
  - A response on the final count wins over the timeout.
- FULL:
  - instr_valid=1.
  - When instr_ready=1: pc_load=1 combinationally in that cycle, fetch_count increments (wraps 0xFFFFFFFF->0), and the next state is REQ. The PC register updates on the same edge, so REQ sees the new pc.
  - instr, instr_pc and instr_fault remain stable while instr_valid=1 and instr_ready=0.
- ERR: terminal until reset. instr_valid=1, instr_fault=10, pc_load never asserted, and instr_ready is ignored.
- Ordering and protocol rules:
  - At most one outstanding request.
  - imem_rsp_valid is ignored outside WAIT, including in the same cycle as request acceptance. Memory guarantees response latency of at least 1 cycle after acceptance.
  - pc_load is asserted only from FULL with no fault or with the misaligned fault. The misaligned case still advances, so the trap path sees the strobe.
  - pc_load is one cycle per consumed instruction, never back-to-back.
- Reset mid-operation: any state returns to IDLE immediately. An in-flight memory response after reset deassertion arrives in IDLE/REQ and is dropped.
- Minimum fetch loop: REQ, then WAIT, then FULL, so a zero-wait memory with decode always ready gives 3 cycles per instruction.

Decomposition:
- Shared package ifetch_pkg: state encodings IDLE/REQ/WAIT/FULL/ERR, fault codes FAULT_NONE/FAULT_MISALIGN/FAULT_TIMEOUT, and the NOP_INSTR constant.
- One natural sub-module, ifetch_timeout_cnt: an 8-bit clear/enable counter with a terminal-count output.

Test Plan:
- Basic fetch:
  - Stimulus: reset, pc=0x00000000, memory accepts immediately, responds 1 cycle later with 0x00500093, decode ready.
  - Required response: instr=0x00500093, instr_pc=0, a single pc_load pulse, fetch_count=1; after the PC stage updates to 0x4, imem_addr=0x4.
- Decode backpressure:
  - Stimulus: hold instr_ready=0 for 5 cycles in FULL.
  - Required response: instr_valid=1 with instr/instr_pc stable, no pc_load; a single pc_load the cycle instr_ready rises.
- Request backpressure:
  - Stimulus: imem_req_ready=0 for 4 cycles with pc=0x100.
  - Required response: imem_req_valid=1 and imem_addr=0x100 held throughout; WAIT entered only after acceptance.
- Misaligned:
  - Stimulus: pc=0x00000102.
  - Required response: no imem_req_valid; instr=0x00000013, instr_fault=01, instr_pc=0x102; pc_load on instr_ready.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, no response.
  - Required response: ERR after 4 WAIT cycles, instr_fault=10, instr=NOP; pc_load stays 0 despite instr_ready=1; a later rsp_valid is ignored; areset low returns to IDLE with all outputs 0.
- Counter wrap and async reset:
  - Stimulus: preload fetch_count to 0xFFFFFFFF via a bench force, then complete one fetch; separately, assert areset mid-WAIT.
  - Required response: fetch_count=0 after the fetch; on the mid-WAIT reset, state clears immediately without a clock edge.
